// File: rtl/data_mem_if.sv
// Request/response bus between a requester and data_mem_ctrl.
interface data_mem_if #(
  parameter int unsigned WORD_SIZE = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 MemRead;
  logic                 MemWrite;
  logic [1:0]           size;
  logic                 unsigned_ld;
  logic [WORD_SIZE-1:0] address;
  logic [WORD_SIZE-1:0] write_data;
  logic [WORD_SIZE-1:0] read_data;
  logic                 rsp_valid;
  logic                 access_err;

  modport master (
    output req_valid, MemRead, MemWrite, size, unsigned_ld, address, write_data,
    input  req_ready, read_data, rsp_valid, access_err
  );

  modport slave (
    input  req_valid, MemRead, MemWrite, size, unsigned_ld, address, write_data,
    output req_ready, read_data, rsp_valid, access_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory with fixed-latency loads and same-edge stores.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_ctrl #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LATENCY    = 1
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned XW    = (WORD_SIZE > 32) ? WORD_SIZE : 32;
  localparam int unsigned CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            mem_q [DEPTH];

  logic                  req_ready_c;
  logic                  rsp_valid_c;
  logic                  acc_c;
  logic                  load_acc_c;
  logic                  store_acc_c;
  logic                  mis_c;
  logic [ADDR_WIDTH-1:0] base_c;
  logic [2:0]            nbytes_c;
  logic [5:0]            nbits_c;
  logic [31:0]           raw_c;
  logic [XW-1:0]         raw_x_c;
  logic [XW-1:0]         wd_x_c;
  logic [XW-1:0]         ext_c;
  logic                  fill_c;
  logic [WORD_SIZE-1:0]  load_val_c;

  logic [WORD_SIZE-1:0]  rd_q;
  logic [WORD_SIZE-1:0]  pend_q;
  logic                  pend_err_q;
  logic                  err_q;

  // Upper address bits are ignored by design
  logic                  unused_addr_c;
  assign unused_addr_c = ^(bus.address >> ADDR_WIDTH);

  // Request decode: acceptance, access width and wrapped base address
  always_comb begin
    acc_c       = bus.req_valid && req_ready_c;
    load_acc_c  = acc_c && bus.MemRead && !bus.MemWrite;
    store_acc_c = acc_c && bus.MemWrite;
    base_c      = bus.address[ADDR_WIDTH-1:0];
    case (bus.size)
      2'b00:   begin nbytes_c = 3'd1; nbits_c = 6'd8;  end
      2'b01:   begin nbytes_c = 3'd2; nbits_c = 6'd16; end
      default: begin nbytes_c = 3'd4; nbits_c = 6'd32; end
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // Misaligned halfword/word or reserved size
  assign mis_c = (bus.size == 2'b11) ||
                 ((bus.size == 2'b01) && base_c[0]) ||
                 ((bus.size == 2'b10) && (base_c[1:0] != 2'b00));
`else
  assign mis_c = 1'b0;
`endif

  // Little-endian gather of up to four bytes, then sign/zero extension
  always_comb begin
    raw_c = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (3'(i) < nbytes_c) begin
        raw_c[8*i +: 8] = mem_q[base_c + ADDR_WIDTH'(i)];
      end
    end
    case (bus.size)
      2'b00:   fill_c = !bus.unsigned_ld && raw_c[7];
      2'b01:   fill_c = !bus.unsigned_ld && raw_c[15];
      default: fill_c = !bus.unsigned_ld && raw_c[31];
    endcase
    raw_x_c = XW'(raw_c);
    ext_c   = '0;
    for (int unsigned b = 0; b < XW; b++) begin
      ext_c[b] = (b < 32'(nbits_c)) ? raw_x_c[b] : fill_c;
    end
    load_val_c = mis_c ? '0 : ext_c[WORD_SIZE-1:0];
  end

  assign wd_x_c = XW'(bus.write_data);

  // Byte-lane store at the accepting edge; contents survive reset
  always_ff @(posedge clk) begin
    if (store_acc_c && !mis_c) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (3'(i) < nbytes_c) begin
          mem_q[base_c + ADDR_WIDTH'(i)] <= wd_x_c[8*i +: 8];
        end
      end
    end
  end

  // FSM state and latency counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a load goes straight to RESP or counts down in WAIT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (load_acc_c) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
    endcase
  end

  // FSM outputs; everything reads as zero while reset is held
  always_comb begin
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    if (!rst) begin
      req_ready_c = (state_q != S_WAIT);
      rsp_valid_c = (state_q == S_RESP);
    end
  end

  // Load data captured at acceptance, published on entry to RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= '0;
      pend_q     <= '0;
      pend_err_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (load_acc_c) begin
        pend_q     <= load_val_c;
        pend_err_q <= mis_c;
      end
      if (state_d == S_RESP) begin
        if (state_q == S_WAIT) begin
          rd_q  <= pend_q;
          err_q <= pend_err_q;
        end else begin
          rd_q  <= load_val_c;
          err_q <= mis_c;
        end
      end else begin
        err_q <= store_acc_c && mis_c;
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = rsp_valid_c;
  assign bus.read_data  = rst ? '0 : rd_q;
  assign bus.access_err = !rst && err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: LATENCY=1 instance against a byte-array model,
// LATENCY=3 instance for wait-state and reset-in-flight behaviour.
module tb_data_mem_ctrl;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst1;
  logic rst3;

  always #5 clk = ~clk;

  data_mem_if #(.WORD_SIZE(32)) b1 ();
  data_mem_if #(.WORD_SIZE(32)) b3 ();

  data_mem_ctrl #(.WORD_SIZE(32), .ADDR_WIDTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(b1)
  );

  data_mem_ctrl #(.WORD_SIZE(32), .ADDR_WIDTH(16), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst3), .bus(b3)
  );

  logic [7:0]  ref1 [65536];
  int unsigned n_vec;
  int unsigned n_bad;
  logic        e_rsp;
  logic        e_err;
  logic [31:0] e_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic misal(input logic [1:0] sz, input logic [15:0] a);
    return ALN && ((sz == 2'b11) || ((sz == 2'b01) && a[0]) ||
                   ((sz == 2'b10) && (a[1:0] != 2'b00)));
  endfunction

  function automatic logic [31:0] mload(input logic [15:0] a, input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = nb(sz);
    for (int k = 0; k < n; k++) v = v | (32'(ref1[16'(a + 16'(k))]) << (8 * k));
    if (!uns && (n < 4) && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic mstore(input logic [15:0] a, input logic [1:0] sz, input logic [31:0] wd);
    for (int k = 0; k < nb(sz); k++) ref1[16'(a + 16'(k))] = wd[8*k +: 8];
  endtask

  // Drive one request onto the LATENCY=1 bus and predict its outcome
  task automatic drv1(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] wd);
    logic m;
    b1.req_valid   = v;
    b1.MemRead     = rd;
    b1.MemWrite    = wr;
    b1.size        = sz;
    b1.unsigned_ld = uns;
    b1.address     = a;
    b1.write_data  = wd;
    m     = misal(sz, a[15:0]);
    e_rsp = 1'b0;
    e_err = 1'b0;
    if (v && wr) begin
      e_err = m;
      if (!m) mstore(a[15:0], sz, wd);
    end else if (v && rd) begin
      e_rsp = 1'b1;
      e_err = m;
      e_rd  = m ? 32'h0 : mload(a[15:0], sz, uns);
    end
  endtask

  task automatic drv3(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a, input logic [31:0] wd);
    b3.req_valid   = v;
    b3.MemRead     = rd;
    b3.MemWrite    = wr;
    b3.size        = sz;
    b3.unsigned_ld = uns;
    b3.address     = a;
    b3.write_data  = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check1(input string tag);
    chk({tag, "/rdy"}, 32'(b1.req_ready),  32'(1'b1));
    chk({tag, "/rsp"}, 32'(b1.rsp_valid),  32'(e_rsp));
    chk({tag, "/rd"},  b1.read_data,       e_rd);
    chk({tag, "/err"}, 32'(b1.access_err), 32'(e_err));
  endtask

  task automatic check3(input string tag, input logic rdy, input logic rsp, input logic [31:0] rd);
    chk({tag, "/rdy"}, 32'(b3.req_ready), 32'(rdy));
    chk({tag, "/rsp"}, 32'(b3.rsp_valid), 32'(rsp));
    chk({tag, "/rd"},  b3.read_data,      rd);
  endtask

  initial begin
    logic [31:0] a;
    n_vec = 0;
    n_bad = 0;
    e_rsp = 1'b0;
    e_err = 1'b0;
    e_rd  = 32'h0;
    rst1  = 1'b1;
    rst3  = 1'b1;
    drv1(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drv3(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // Outputs held at zero during reset
    chk("rst1/rdy", 32'(b1.req_ready),  32'h0);
    chk("rst1/rsp", 32'(b1.rsp_valid),  32'h0);
    chk("rst1/rd",  b1.read_data,       32'h0);
    chk("rst1/err", 32'(b1.access_err), 32'h0);
    chk("rst3/rdy", 32'(b3.req_ready),  32'h0);
    chk("rst3/rsp", 32'(b3.rsp_valid),  32'h0);
    chk("rst3/rd",  b3.read_data,       32'h0);
    rst1 = 1'b0;
    rst3 = 1'b0;
    tick();
    check1("post_rst");

    // Word store then word load, one-cycle response
    drv1(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0010, 32'h8765_4321);
    tick(); check1("st_w10");
    drv1(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0010, 32'h0);
    tick(); check1("ld_w10"); chk("ld_w10/val", b1.read_data, 32'h8765_4321);

    // Back-to-back sub-word loads, one response per cycle
    drv1(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0013, 32'h0);
    tick(); check1("ld_bs13"); chk("ld_bs13/val", b1.read_data, 32'hFFFF_FF87);
    drv1(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0013, 32'h0);
    tick(); check1("ld_bu13"); chk("ld_bu13/val", b1.read_data, 32'h0000_0087);
    drv1(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0012, 32'h0);
    tick(); check1("ld_hs12"); chk("ld_hs12/val", b1.read_data, 32'hFFFF_8765);
    drv1(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0010, 32'h0);
    tick(); check1("hold"); chk("hold/val", b1.read_data, 32'hFFFF_8765);

    // Store accepted during RESP does not disturb the response
    drv1(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0010, 32'h0);
    tick(); check1("ld_pre");
    drv1(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0010, 32'hDEAD_BEEF);
    tick(); check1("st_resp"); chk("st_resp/val", b1.read_data, 32'h8765_4321);
    drv1(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0010, 32'h0);
    tick(); check1("ld_post"); chk("ld_post/val", b1.read_data, 32'hDEAD_BEEF);

    // Read and write together: store only
    drv1(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0020, 32'h0102_0304);
    tick(); check1("rw_both");
    drv1(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 32'h0020, 32'h0);
    tick(); check1("rw_ld"); chk("rw_ld/val", b1.read_data, 32'h0102_0304);

    // Word store wrapping past the top of the array
    drv1(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_FFFF, 32'hA5B6_C7D8);
    tick(); check1("st_wrap");
    drv1(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_FFFF, 32'h0);
    tick(); check1("ld_wrap");
`ifndef DMEM_ALIGN_CHECK_EN
    chk("ld_wrap/val", b1.read_data, 32'hA5B6_C7D8);
    drv1(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0000, 32'h0);
    tick(); check1("ld_b0"); chk("ld_b0/val", b1.read_data, 32'h0000_00C7);
`endif

    // Misaligned word store
    drv1(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0011, 32'h1122_3344);
    tick(); check1("st_mis"); chk("st_mis/err", 32'(b1.access_err), 32'(ALN));
    drv1(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0010, 32'h0);
    tick(); check1("ld_mis");
`ifdef DMEM_ALIGN_CHECK_EN
    chk("ld_mis/val", b1.read_data, 32'hDEAD_BEEF);
`else
    chk("ld_mis/val", b1.read_data, 32'h2233_44EF);
`endif

    // Valid without an operation, and operation without valid
    drv1(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0010, 32'h0);
    tick(); check1("nop_v");
    drv1(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0010, 32'h5555_5555);
    tick(); check1("nop_nv");

    // Prefill the random-access window
    for (int i = 0; i < 20; i++) begin
      a = (i < 16) ? 32'(4 * i) : 32'(16'hFFF0 + 16'(4 * (i - 16)));
      drv1(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, a, $urandom);
      tick(); check1("fill");
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 47))
                                      : 32'(16'hFFF0 + 16'($urandom_range(0, 15)));
      a[31:16] = 16'($urandom);
      drv1(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
      tick(); check1("rand");
    end
    drv1(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

    // LATENCY=3: wait states, blocked requests, back-to-back load
    drv3(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0020, 32'h0BAD_F00D);
    tick(); check3("l3_st", 1'b1, 1'b0, 32'h0);
    drv3(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0020, 32'h0);
    tick(); check3("l3_c1", 1'b0, 1'b0, 32'h0);
    drv3(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0020, 32'hFFFF_FFFF);
    tick(); check3("l3_c2", 1'b0, 1'b0, 32'h0);
    drv3(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0020, 32'h0);
    tick(); check3("l3_c3", 1'b1, 1'b1, 32'h0BAD_F00D);
    drv3(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0020, 32'h0);
    tick(); check3("l3_c4", 1'b0, 1'b0, 32'h0BAD_F00D);
    drv3(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0020, 32'h0);
    tick(); check3("l3_c5", 1'b0, 1'b0, 32'h0BAD_F00D);
    tick(); check3("l3_c6", 1'b1, 1'b1, 32'h0BAD_F00D);
    tick(); check3("l3_c7", 1'b1, 1'b0, 32'h0BAD_F00D);

    // LATENCY=3: reset while a load is pending
    drv3(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0020, 32'h0);
    tick(); check3("l3_w", 1'b0, 1'b0, 32'h0BAD_F00D);
    drv3(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    rst3 = 1'b1;
    tick(); check3("l3_rst", 1'b0, 1'b0, 32'h0);
    chk("l3_rst/err", 32'(b3.access_err), 32'h0);
    tick();
    rst3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); check3("l3_after", 1'b1, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
